// File: rtl/pkt_feeder.sv
// pkt_feeder: packet-aware byte FIFO that stores whole packets and releases
// them downstream only when complete and when the number of unacknowledged
// packets is below MAX_INFLIGHT.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_vld/in_sop/in_eop/in_data, in_rdy
//                             input byte stream with packet framing
//   data_out_vld/sop_out_vld/eop_out_vld/data_out
//                             registered output byte stream, zero when idle
//   fb_vld/fb_eop             downstream feedback, one packet consumed
//   inflight                  packets sent but not yet acknowledged
//   ovf_err                   sticky flag, an oversize packet was dropped
module pkt_feeder #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_vld,
  input  logic                                  in_sop,
  input  logic                                  in_eop,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  output logic                                  in_rdy,
  output logic                                  data_out_vld,
  output logic                                  sop_out_vld,
  output logic                                  eop_out_vld,
  output logic [DATA_WIDTH-1:0]                 data_out,
  input  logic                                  fb_vld,
  input  logic                                  fb_eop,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
  output logic                                  ovf_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned EW = DATA_WIDTH + 2;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  // Entry layout: {sop, eop, data}
  logic [EW-1:0]         r_mem [DEPTH];
  logic [PW-1:0]         r_wr_commit, r_wr_work, r_rd;
  logic                  r_in_pkt, r_discard, r_ovf;
  logic [CW-1:0]         r_pkt_cnt;
  logic [IW-1:0]         r_inflight;
  state_t                r_state, w_state_nxt;
  logic                  r_dvld, r_sop, r_eop;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  w_full, w_ovf, w_drop, w_acc;
  logic                  w_wr_en, w_commit_pkt;
  logic [AW-1:0]         w_wr_addr;
  logic [PW-1:0]         w_work_nxt, w_commit_nxt;
  logic                  w_in_pkt_nxt, w_discard_nxt;
  logic [EW-1:0]         w_entry;
  logic                  w_fb_dec, w_room, w_go, w_pop, w_start, w_pop_eop;

  // Occupancy is measured against the working pointer so a partial packet counts
  assign w_full = ((r_wr_work - r_rd) == PW'(DEPTH));
  // Only a partial packet fills the FIFO: it can never complete, so drop it
  assign w_ovf  = w_full & (r_pkt_cnt == '0) & r_in_pkt;
  assign w_drop = r_discard | w_ovf;
  assign in_rdy = ~rst & (w_drop | ~w_full);
  assign w_acc  = in_vld & in_rdy;

  // Input framing: packet start/restart, append, commit, oversize discard
  always_comb begin
    w_wr_en       = 1'b0;
    w_wr_addr     = r_wr_work[AW-1:0];
    w_work_nxt    = r_wr_work;
    w_commit_nxt  = r_wr_commit;
    w_in_pkt_nxt  = r_in_pkt;
    w_discard_nxt = r_discard;
    w_commit_pkt  = 1'b0;
    if (w_ovf) begin
      w_work_nxt    = r_wr_commit;
      w_in_pkt_nxt  = 1'b0;
      w_discard_nxt = 1'b1;
    end
    if (w_acc) begin
      if (w_drop) begin
        w_discard_nxt = ~in_eop;
      end else if (in_sop) begin
        // A new sop always restarts at the committed pointer
        w_wr_en    = 1'b1;
        w_wr_addr  = r_wr_commit[AW-1:0];
        w_work_nxt = r_wr_commit + PW'(1);
        if (in_eop) begin
          w_commit_nxt = r_wr_commit + PW'(1);
          w_in_pkt_nxt = 1'b0;
          w_commit_pkt = 1'b1;
        end else begin
          w_in_pkt_nxt = 1'b1;
        end
      end else if (r_in_pkt) begin
        w_wr_en    = 1'b1;
        w_work_nxt = r_wr_work + PW'(1);
        if (in_eop) begin
          w_commit_nxt = r_wr_work + PW'(1);
          w_in_pkt_nxt = 1'b0;
          w_commit_pkt = 1'b1;
        end
      end
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= {in_sop, in_eop, in_data};
  end

  assign w_entry   = r_mem[r_rd[AW-1:0]];
  assign w_fb_dec  = fb_vld & fb_eop & (r_inflight != '0);
  // A same-cycle acknowledgement frees a slot for an immediate start
  assign w_room    = (r_inflight < IW'(MAX_INFLIGHT)) | w_fb_dec;
  // r_dvld low guarantees at least one idle cycle between packets
  assign w_go      = (r_pkt_cnt != '0) & w_room & ~r_dvld;
  assign w_pop_eop = w_pop & w_entry[EW-2];

  // Output FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Output FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go && !w_entry[EW-2]) w_state_nxt = S_SEND;
      S_SEND:  if (w_entry[EW-2])          w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output FSM decode: pop in the decision cycle and every SEND cycle
  always_comb begin
    w_pop   = 1'b0;
    w_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop   = w_go;
        w_start = w_go;
      end
      S_SEND:  w_pop = 1'b1;
      default: w_pop = 1'b0;
    endcase
  end

  // Pointers, counters, flags and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_commit <= '0;
      r_wr_work   <= '0;
      r_rd        <= '0;
      r_in_pkt    <= 1'b0;
      r_discard   <= 1'b0;
      r_ovf       <= 1'b0;
      r_pkt_cnt   <= '0;
      r_inflight  <= '0;
      r_dvld      <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_data      <= '0;
    end else begin
      r_wr_commit <= w_commit_nxt;
      r_wr_work   <= w_work_nxt;
      r_rd        <= r_rd + PW'(w_pop);
      r_in_pkt    <= w_in_pkt_nxt;
      r_discard   <= w_discard_nxt;
      r_ovf       <= r_ovf | w_ovf;
      r_pkt_cnt   <= r_pkt_cnt + CW'(w_commit_pkt) - CW'(w_pop_eop);
      r_inflight  <= r_inflight + IW'(w_start) - IW'(w_fb_dec);
      r_dvld      <= w_pop;
      r_sop       <= w_pop & w_entry[EW-1];
      r_eop       <= w_pop_eop;
      r_data      <= w_pop ? w_entry[DATA_WIDTH-1:0] : '0;
    end
  end

  assign data_out_vld = r_dvld;
  assign sop_out_vld  = r_sop;
  assign eop_out_vld  = r_eop;
  assign data_out     = r_data;
  assign inflight     = r_inflight;
  assign ovf_err      = r_ovf;

endmodule

// File: tb/tb_pkt_feeder.sv
// Self-checking bench for pkt_feeder: packet-level queue model plus a
// per-cycle output compare, and directed scenarios with literal expectations.
module tb_pkt_feeder;
  localparam int DW = 8;
  localparam int DEPTH = 64;
  localparam int MAXI = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_rdy;
  logic          data_out_vld, sop_out_vld, eop_out_vld;
  logic [DW-1:0] data_out;
  logic          fb_vld = 1'b0, fb_eop = 1'b0;
  logic [1:0]    inflight;
  logic          ovf_err;

  pkt_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .in_rdy(in_rdy),
    .data_out_vld(data_out_vld), .sop_out_vld(sop_out_vld),
    .eop_out_vld(eop_out_vld), .data_out(data_out),
    .fb_vld(fb_vld), .fb_eop(fb_eop),
    .inflight(inflight), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model state: packets that must appear downstream, in order
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] part_q[$];
  bit m_in_pkt = 0, m_discard = 0, m_ovf = 0;
  int m_inf = 0;
  bit fb_q = 0, rst_q = 1;
  bit prev_vld = 0, prev_eop = 0;
  int n_out = 0;
  int last_sop_data = 0;

  function automatic void model_accept(bit s, bit e, logic [DW-1:0] d);
    if (m_discard) begin
      if (e) m_discard = 0;
      return;
    end
    if (s) begin
      part_q.delete();
      m_in_pkt = 1;
    end
    if (!m_in_pkt) return;
    part_q.push_back({s, e, d});
    if (e) begin
      foreach (part_q[i]) exp_q.push_back(part_q[i]);
      part_q.delete();
      m_in_pkt = 0;
    end else if (part_q.size() == DEPTH) begin
      part_q.delete();
      m_in_pkt  = 0;
      m_discard = 1;
      m_ovf     = 1;
    end
  endfunction

  always @(posedge clk) begin
    rst_q = rst;
    fb_q  = fb_vld & fb_eop;
    if (rst) begin
      exp_q.delete();
      part_q.delete();
      m_in_pkt  = 0;
      m_discard = 0;
      m_ovf     = 0;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (rst) check("in_rdy_in_reset", int'(in_rdy), 0);
    if (rst_q) begin
      check("reset_outputs", int'({data_out_vld, sop_out_vld, eop_out_vld, data_out}), 0);
      check("reset_inflight", int'(inflight), 0);
      check("reset_ovf", int'(ovf_err), 0);
      m_inf = 0; prev_vld = 0; prev_eop = 0;
    end else begin
      if (data_out_vld) begin
        n_out++;
        if (sop_out_vld) last_sop_data = int'(data_out);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_out: got data 0x%0h sop %0d eop %0d expected no output at %0t",
                   data_out, sop_out_vld, eop_out_vld, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_entry", int'({sop_out_vld, eop_out_vld, data_out}), int'(e));
        end
        if (prev_vld && prev_eop) check("idle_between_pkts", int'(data_out_vld), 0);
      end else begin
        check("idle_zero", int'({sop_out_vld, eop_out_vld, data_out}), 0);
        if (prev_vld && !prev_eop) check("no_gap_in_pkt", int'(data_out_vld), 1);
      end
      m_inf = m_inf + int'(sop_out_vld) - ((fb_q && m_inf > 0) ? 1 : 0);
      check("inflight", int'(inflight), m_inf);
      check("inflight_max", int'(int'(inflight) <= MAXI), 1);
      if (!m_ovf) check("ovf_early", int'(ovf_err), 0);
      prev_vld = data_out_vld;
      prev_eop = eop_out_vld;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input bit s, input bit e, input logic [DW-1:0] d);
    bit acc = 0;
    in_vld = 1'b1; in_sop = s; in_eop = e; in_data = d;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = in_rdy;
      tick();
    end
    if (acc) model_accept(s, e, d);
    else begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got in_rdy 0 expected 1 within 300 cycles at %0t", $time);
    end
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
  endtask

  task automatic send_seq(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) send_byte(i == 0, i == n - 1, base + DW'(i));
  endtask

  task automatic fb_pulse(input bit e);
    fb_vld = 1'b1; fb_eop = e;
    tick();
    fb_vld = 1'b0; fb_eop = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300000 ns");
    $fatal(1);
  end

  initial begin
    int n0;
    bit got;
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t1_in_rdy", int'(in_rdy), 1);
    check("t1_out_vld", int'(data_out_vld), 0);
    check("t1_inflight", int'(inflight), 0);
    check("t1_ovf", int'(ovf_err), 0);
    tick();

    // Three-byte packet timing and content
    send_byte(1, 0, 8'h11); send_byte(0, 0, 8'h22); send_byte(0, 1, 8'h33);
    @(negedge clk); check("t2_decision_idle", int'(data_out_vld), 0); tick();
    @(negedge clk);
    check("t2_b0_sop", int'(sop_out_vld), 1);
    check("t2_b0_data", int'(data_out), 'h11);
    check("t2_inflight", int'(inflight), 1);
    tick();
    @(negedge clk);
    check("t2_b1_data", int'({sop_out_vld, eop_out_vld, data_out}), 'h022);
    tick();
    @(negedge clk);
    check("t2_b2_eop", int'({sop_out_vld, eop_out_vld, data_out}), 'h133);
    tick();
    fb_pulse(1); repeat (2) tick();
    check("t2_inflight_ack", int'(inflight), 0);

    // Inflight limit
    send_seq(2, 8'h31); send_seq(2, 8'h41); send_seq(2, 8'h51);
    repeat (30) tick();
    check("t3_inflight_full", int'(inflight), 2);
    check("t3_third_held", exp_q.size(), 2);
    fb_pulse(1);
    @(negedge clk);
    check("t3_third_sop", int'(sop_out_vld), 1);
    check("t3_third_data", int'(data_out), 'h51);
    tick();
    repeat (5) tick();
    check("t3_inflight_back", int'(inflight), 2);
    fb_pulse(0); tick();
    check("t3_fb_no_eop", int'(inflight), 2);
    fb_pulse(1); fb_pulse(1); fb_pulse(1); tick();
    check("t3_no_underflow", int'(inflight), 0);

    // Full FIFO backpressure
    send_seq(64, 8'h00);
    @(negedge clk); check("t4_full_rdy_low", int'(in_rdy), 0); tick();
    send_seq(10, 8'h80);
    repeat (100) tick();
    check("t4_all_delivered", exp_q.size(), 0);
    fb_pulse(1); fb_pulse(1); tick();
    check("t4_inflight_clear", int'(inflight), 0);

    // Oversize packet
    n0 = n_out;
    send_seq(70, 8'h00);
    repeat (5) tick();
    check("t5_ovf_set", int'(ovf_err), 1);
    check("t5_nothing_out", n_out, n0);
    send_seq(4, 8'hC1);
    repeat (20) tick();
    check("t5_next_pkt_bytes", n_out, n0 + 4);
    check("t5_drained", exp_q.size(), 0);
    check("t5_ovf_sticky", int'(ovf_err), 1);
    fb_pulse(1); tick();

    // Stray byte and restarted packet
    n0 = n_out;
    send_byte(0, 0, 8'hAA);
    send_byte(1, 0, 8'h01); send_byte(0, 0, 8'h02);
    send_byte(1, 0, 8'h10); send_byte(0, 0, 8'h20); send_byte(0, 1, 8'h30);
    repeat (10) tick();
    check("t6_out_bytes", n_out, n0 + 3);
    check("t6_sop_data", last_sop_data, 'h10);
    fb_pulse(1); tick();

    // Reset during SEND
    n0 = n_out;
    send_seq(5, 8'hD1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (sop_out_vld) got = 1;
      else tick();
    end
    check("t7_sop_seen", int'(got), 1);
    tick();
    rst = 1'b1;
    @(negedge clk); check("t7_byte2", int'(data_out), 'hD2);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t7_out_cleared", int'({data_out_vld, sop_out_vld, eop_out_vld, data_out}), 0);
    check("t7_inflight_cleared", int'(inflight), 0);
    check("t7_in_rdy", int'(in_rdy), 1);
    tick();
    repeat (10) tick();
    check("t7_no_more_bytes", n_out, n0 + 2);
    send_seq(2, 8'hE1);
    repeat (10) tick();
    check("t7_recovered", n_out, n0 + 4);
    check("t7_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
